// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: captures a byte on an accepted start strobe and shifts
// it out LSB first, reporting busy and a one-cycle done pulse per frame.
module uart_tx_serializer #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iTx,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int            CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx_serial;
    logic               r_tx_busy;
    logic               r_tx_done;
    logic               w_bit_end;

    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    // Frame sequencer: state, bit timing, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
                    if (iTx) begin
                        r_shift     <= tx_data;
                        r_state     <= S_START;
                        r_tx_serial <= 1'b0;
                        r_tx_busy   <= 1'b1;
                    end else begin
                        r_tx_serial <= 1'b1;
                        r_tx_busy   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt  <= '0;
                        r_bit_idx   <= 3'd0;
                        r_state     <= S_DATA;
                        r_tx_serial <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state     <= S_STOP;
                            r_tx_serial <= 1'b1;
                        end else begin
                            // Next line bit is the one about to land in bit 0
                            r_shift     <= {1'b0, r_shift[7:1]};
                            r_bit_idx   <= r_bit_idx + 3'd1;
                            r_tx_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                    r_tx_serial <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_baud_cnt  <= '0;
                    r_bit_idx   <= 3'd0;
                    r_tx_serial <= 1'b1;
                    r_tx_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial = r_tx_serial;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       iTx;
    logic [7:0] tx_data;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_errors = 0;

    int         rx_off = 0;
    bit         rx_active = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         done_cnt = 0;

    uart_tx_serializer #(
        .CLK_FREQ     (50000000),
        .BAUD         (115200),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iTx       (iTx),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Receiver model: start found on first low sample, bits sampled mid-bit
    always @(negedge clk) begin
        if (!rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx_serial == 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
            end
        end else begin
            rx_off++;
            if (rx_off >= 6 && rx_off <= 34 && (rx_off % 4) == 2)
                rx_byte = {tx_serial, rx_byte[7:1]};
            if (rx_off == 38) begin
                if (tx_serial) rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
    end

    // Sends one frame starting at a negedge; exp[i] is the level of line bit i.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] exp, input string tag,
                             input bit keep, input int mid);
        iTx     = 1'b1;
        tx_data = d;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (k == mid) begin
                iTx     = 1'b1;
                tx_data = 8'hA5;
            end else if (!keep) begin
                iTx = 1'b0;
            end
            check({tag, "_line"}, 32'(tx_serial), 32'(exp[k / 4]));
            check({tag, "_busy"}, 32'(tx_busy), 32'd1);
            check({tag, "_nodone"}, 32'(tx_done), 32'd0);
            @(negedge clk);
        end
        if (!keep) iTx = 1'b0;
        check({tag, "_done"}, 32'(tx_done), 32'd1);
        check({tag, "_donebusy"}, 32'(tx_busy), 32'd0);
        check({tag, "_doneline"}, 32'(tx_serial), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check({tag, "_idle_line"}, 32'(tx_serial), 32'd1);
            check({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
            check({tag, "_idle_done"}, 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;
        int done_base;
        rst     = 1'b0;
        iTx     = 1'b0;
        tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_line", 32'(tx_serial), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        rst = 1'b1;
        check_idle("post_reset", 2);

        // 8'h37 -> 0,1,1,1,0,1,1,0,0,1
        run_frame(8'h37, 10'b10_0110_1110, "f37", 1'b0, -1);
        check_idle("f37", 3);

        run_frame(8'h00, 10'b10_0000_0000, "f00", 1'b0, -1);
        check_idle("f00", 1);
        run_frame(8'hFF, 10'b11_1111_1110, "fFF", 1'b0, -1);
        check_idle("fFF", 1);

        // Strobe with 8'hA5 at cycle N+12 must not disturb the 8'h37 frame
        run_frame(8'h37, 10'b10_0110_1110, "fmid", 1'b0, 11);
        check_idle("fmid", 45);

        // iTx held high: back-to-back 8'h3C frames, one idle cycle between
        run_frame(8'h3C, 10'b10_0111_1000, "b2b0", 1'b1, -1);
        run_frame(8'h3C, 10'b10_0111_1000, "b2b1", 1'b1, -1);
        run_frame(8'h3C, 10'b10_0111_1000, "b2b2", 1'b0, -1);
        check_idle("b2b", 2);

        // Asynchronous reset at cycle N+20 (data bit 3 of 8'h37 = 0 on the line)
        iTx     = 1'b1;
        tx_data = 8'h37;
        @(negedge clk);
        iTx = 1'b0;
        repeat (19) @(negedge clk);
        check("rst_pre_busy", 32'(tx_busy), 32'd1);
        check("rst_pre_line", 32'(tx_serial), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_line", 32'(tx_serial), 32'd1);
        check("rst_async_busy", 32'(tx_busy), 32'd0);
        check("rst_async_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_idle("rst_rel", 3);
        // 8'h55 -> 0,1,0,1,0,1,0,1,0,1
        run_frame(8'h55, 10'b10_1010_1010, "f55", 1'b0, -1);
        check_idle("f55", 2);

        // Upstream handshake: issue 8'h37, wait for tx_done, repeat
        rx_q.delete();
        done_base = done_cnt;
        for (int f = 0; f < 3; f++) begin
            iTx     = 1'b1;
            tx_data = 8'h37;
            @(negedge clk);
            iTx    = 1'b0;
            cycles = 0;
            while (!tx_done && cycles < 100) begin
                @(negedge clk);
                cycles++;
            end
            check("hs_done_seen", 32'(tx_done), 32'd1);
            check("hs_latency", 32'(cycles), 32'd40);
        end
        check_idle("hs", 3);
        check("hs_done_count", 32'(done_cnt - done_base), 32'd3);
        check("hs_rx_count", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size())
                check("hs_rx_byte", 32'(rx_q[i]), 32'h37);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- 8N1 UART transmit serializer, directly downstream of the start-strobe/data sequencer.
- Accepts a start strobe (iTx) plus an 8-bit byte (tx_data) and shifts the frame out on tx_serial, LSB first, at a fixed baud rate.
- Reports busy, and returns a one-cycle done pulse so the upstream FSM can leave its wait state and issue the next byte.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz (DE10 board clock).
- BAUD, 115200, line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clock cycles per line bit. Must be >=2. Benches override it to 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- iTx  input  1  start strobe; sampled only while idle.
- tx_data  input  8  byte to send; captured on the accepted-strobe edge.
- tx_serial  output  1  UART line; idle high.
- tx_busy  output  1  high from the cycle after acceptance until the end of the stop bit.
- tx_done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (rst=0, asynchronous): tx_serial=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_serial=1.
  - If iTx=1 on edge N: latch tx_data into the shift register, go to START, clear the baud counter.
  - From cycle N+1: tx_serial=0, tx_busy=1.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1. Every line bit is held exactly CLKS_PER_BIT cycles.
  - Counter width is ceil(log2(CLKS_PER_BIT)). No overflow is possible.
- START: on terminal count, go to DATA with bit index 0; tx_serial = shift register bit 0.
- DATA:
  - On each terminal count, shift right and increment the bit index.
  - After the bit-7 period, go to STOP; tx_serial=1.
- STOP:
  - Hold tx_serial=1 for CLKS_PER_BIT cycles.
  - On terminal count, go to IDLE; tx_busy=0 and tx_done=1 in that same cycle, which is N+1+10*CLKS_PER_BIT.
  - tx_done drops after one cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first low cycle to the first idle cycle.
- iTx while tx_busy=1: ignored. tx_data changes during a frame do not affect the frame in progress.
- iTx held high continuously: a new frame is accepted on every cycle the block is IDLE, giving back-to-back frames with exactly one idle-high cycle between stop bit and next start bit.
- iTx=1 in the tx_done cycle: accepted. tx_done=1 and a new capture occur on the same edge.
- Reset mid-frame: line returns high immediately. No done pulse. A partial frame is not resumed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then iTx=1 for one cycle with tx_data=8'h37 (CLKS_PER_BIT=4) -> tx_serial per 4-cycle bit: 0,1,1,1,0,1,1,0,0,1. tx_busy high for 40 cycles. One tx_done pulse at cycle N+41. Line high afterwards.
- tx_data=8'h00 and then 8'hFF -> line 0 for 9 bit-times then 1; start 0, then 1 for 9 bit-times. Each bit exactly 4 cycles.
- Strobe mid-frame: iTx=1 with 8'hA5 at cycle N+12 during an 8'h37 frame -> 8'h37 frame is unchanged. No second frame and no extra tx_done.
- iTx held high with tx_data=8'h3C -> consecutive frames of 40 busy cycles each, separated by a single idle cycle. One tx_done per frame, coinciding with the next acceptance edge.
- rst=0 asynchronously at cycle N+20 of a frame -> tx_serial=1, tx_busy=0, tx_done=0 before the next clk edge. After release, a new 8'h55 frame transmits correctly.
- Upstream-sequencer handshake: the sequencer issues iTx with 8'h37 and waits for tx_done -> exactly one frame is transmitted per tx_done. The received byte decodes to 8'h37 in a bench UART receiver model.
